seg_display_arbiter: RTL
========================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the single 4-digit multiplexed seven-segment driver between N_REQ requesters
//  (game state, timers, sensor readouts, messages). Each requester raises req with a
//  16-bit BCD word; the arbiter grants one owner and forwards its word to the driver's
//  number input. Arbitration is round-robin with a minimum dwell and urgent preemption.
// PARAMETERS
//  N_REQ        4           number of requesters (2..8)
//  DWELL_CYCLES 50_000_000  clk cycles an owner keeps the display before rotation (1 s @ 50 MHz)
//  CNT_W        26          dwell counter width; must satisfy 2**CNT_W > DWELL_CYCLES
// PORTS
//  clk       in   1          system clock
//  rst       in   1          synchronous reset, active-high
//  req       in   N_REQ      per-requester display request, level, held while wanted
//  urgent    in   N_REQ      per-requester urgent flag, meaningful only with req
//  data      in   16*N_REQ   requester i word at data[16*i+15:16*i], 4 BCD nibbles
//  grant     out  N_REQ      one-hot current owner, all-zero when idle
//  owner     out  3          index of current owner, 0 when idle
//  number    out  16         word to display driver
//  active    out  1          1 while an owner holds the display
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): grant=0, owner=0, number=16'h0000, active=0,
//   dwell counter=0, rr pointer=0 (requester 0 has top priority first), state=IDLE.
//   Reset mid-operation drops the grant in the same edge; no partial state survives.
//  States: IDLE, HOLD. All outputs registered.
//  IDLE: number=0. If req!=0, next edge: pick winner, go HOLD, grant/owner/active set,
//   dwell=0. Grant latency: 1 cycle from req to grant.
//  Pick rule: if any (req&urgent) nonzero pick among those, else among req; within the set
//   first asserted index at or after rr pointer, wrapping N_REQ-1 -> 0. On every grant
//   rr pointer := winner+1 (mod N_REQ).
//  HOLD, evaluated each edge, first match wins:
//   1. req[owner]=0 (release): if other req pending, re-pick and grant next edge (no idle
//      gap); else IDLE, grant=0, number=0.
//   2. urgent preemption: owner not urgent and some other i has req&urgent -> re-pick
//      among urgent, regardless of dwell.
//   3. dwell==DWELL_CYCLES-1: if another req pending, re-pick (excluding owner unless it is
//      the only candidate); else dwell restarts at 0, owner kept.
//   4. otherwise dwell+1.
//  Urgent owner is preempted only by release or dwell expiry to another urgent requester.
//  number = data slice of owner, registered: follows owner's data with 1-cycle latency
//   while held; on ownership change the new owner's word appears with the new grant.
//  Simultaneous release and expiry: release rule applies. Requester dropping and another
//   raising in the same cycle: handover in one edge, grant never two-hot.
//  Invariants: $onehot0(grant); active == |grant; grant[owner]==active.
// STRUCTURE
//  Package seg_disp_pkg: state enum {IDLE,HOLD}, default N_REQ, DWELL_CYCLES, data slice
//   width constant (16), idx width function.
//  Sub-module rr_pick: combinational round-robin picker (inputs candidate mask, pointer;
//   outputs valid, index). Instantiated once, fed urgent-or-normal mask by the FSM.
//  Top holds FSM, dwell counter, rr pointer, output registers.
// TESTING (DWELL_CYCLES=8 for sim)
//  1. Reset then req=4'b0100, data2=16'h1234 -> after 1 edge grant=0100, owner=2,
//     number=16'h1234, active=1; assert rst mid-hold -> next edge all outputs 0.
//  2. req=4'b1111 held, no urgent -> owners rotate 0,1,2,3,0 every 8 cycles, grant one-hot.
//  3. Sole requester 1 held 30 cycles -> grant stays 0010, no glitch at dwell expiry.
//  4. Owner 0 holding, at cycle 3 req[3]&urgent[3] -> next edge owner=3, number=data3;
//     urgent owner 3 not displaced by urgent[1] until its dwell expires.
//  5. Owner 2 drops req on the expiry cycle while req[0]=1 -> next edge owner=0, no IDLE cycle.
//  6. Owner 1 changes data 16'h0001->16'h0099 -> number updates one cycle later; all req
//     drop -> next edge IDLE, number=0, active=0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Indices are carried as 3-bit values so the owner port is fixed-width for 2..8 requesters.
package seg_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int N_REQ_DEFAULT = 4;
   localparam int DWELL_DEFAULT = 50_000_000;
   localparam int CNT_W_DEFAULT = 26;
   localparam int DATA_W        = 16;
   localparam int IDX_W         = 3;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping N-1 -> 0.
// The loop walks offsets from farthest to nearest so the nearest candidate is the last assignment.
module rr_pick
   import seg_disp_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = |mask;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[(int'(ptr) + k) % N]) begin
            idx = IDX_W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit display driver, with a minimum
// dwell per owner and urgent preemption. All outputs come straight from registers.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int N_REQ        = N_REQ_DEFAULT,
   parameter int DWELL_CYCLES = DWELL_DEFAULT,
   parameter int CNT_W        = CNT_W_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        urgent,
   input  logic [DATA_W*N_REQ-1:0] data,
   output logic [N_REQ-1:0]        grant,
   output logic [IDX_W-1:0]        owner,
   output logic [DATA_W-1:0]       number,
   output logic                    active
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [N_REQ-1:0]    grant_reg, grant_next;
   logic [IDX_W-1:0]    owner_reg, owner_next;
   logic [DATA_W-1:0]   number_reg, number_next;
   logic                active_reg, active_next;
   logic [CNT_W-1:0]    dwell_reg, dwell_next;
   logic [IDX_W-1:0]    rr_reg, rr_next;

   logic [N_REQ-1:0]    urg_req, base, others, pick_mask;
   logic                own_req, own_urg, do_grant;
   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic [DATA_W-1:0]   owner_data, pick_data;

   // grant_reg is the owner's one-hot bit while holding, so it doubles as the owner mask.
   assign urg_req    = req & urgent;
   assign base       = (|urg_req) ? urg_req : req;
   assign others     = base & ~grant_reg;
   assign own_req    = |(req & grant_reg);
   assign own_urg    = |(urgent & grant_reg);
   assign owner_data = data[DATA_W*owner_reg +: DATA_W];
   assign pick_data  = data[DATA_W*pick_idx +: DATA_W];

   // The holder is excluded from the candidates unless it is the only one left.
   assign pick_mask = (state_reg == HOLD && own_req && (|others)) ? others : base;

   rr_pick #(
      .N(N_REQ)
   ) u_pick (
      .mask  (pick_mask),
      .ptr   (rr_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      owner_next  = owner_reg;
      number_next = number_reg;
      active_next = active_reg;
      dwell_next  = dwell_reg;
      rr_next     = rr_reg;
      do_grant    = 1'b0;

      case (state_reg)
         IDLE: begin
            number_next = '0;
            if (pick_valid) begin
               do_grant = 1'b1;
            end
         end
         HOLD: begin
            if (!own_req) begin
               if (pick_valid) begin
                  do_grant = 1'b1;
               end else begin
                  state_next  = IDLE;
                  grant_next  = '0;
                  owner_next  = '0;
                  number_next = '0;
                  active_next = 1'b0;
                  dwell_next  = '0;
               end
            end else if (!own_urg && (|(urg_req & ~grant_reg))) begin
               do_grant = 1'b1;
            end else if (dwell_reg == DWELL_LAST) begin
               if (|others) begin
                  do_grant = 1'b1;
               end else begin
                  dwell_next  = '0;
                  number_next = owner_data;
               end
            end else begin
               dwell_next  = dwell_reg + CNT_W'(1);
               number_next = owner_data;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (do_grant) begin
         state_next  = HOLD;
         grant_next  = N_REQ'(1) << pick_idx;
         owner_next  = pick_idx;
         number_next = pick_data;
         active_next = 1'b1;
         dwell_next  = '0;
         rr_next     = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         owner_reg  <= '0;
         number_reg <= '0;
         active_reg <= 1'b0;
         dwell_reg  <= '0;
         rr_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         owner_reg  <= owner_next;
         number_reg <= number_next;
         active_reg <= active_next;
         dwell_reg  <= dwell_next;
         rr_reg     <= rr_next;
      end
   end

   assign grant  = grant_reg;
   assign owner  = owner_reg;
   assign number = number_reg;
   assign active = active_reg;

endmodule
